// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and defaults for the matrix multiplier datapath
package matmul_pkg;

    localparam int DATA_W_DEFAULT = 32;

    localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [1:0] ST_WAIT_ENC   = 2'd1;
    localparam logic [1:0] ST_STREAM_ENC = 2'd2;
    localparam logic [1:0] ST_FLUSH_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_WAIT   = ST_WAIT_ENC,
        ST_STREAM = ST_STREAM_ENC,
        ST_FLUSH  = ST_FLUSH_ENC
    } state_t;

endpackage

// File: rtl/mat_index_counter.sv
// rtl/mat_index_counter.sv - row-major (row, col) counter over an N x N matrix
module mat_index_counter #(
    parameter int N     = 4,
    parameter int N_LEN = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [N_LEN-1:0] row_o,
    output logic [N_LEN-1:0] col_o,
    output logic             tc_o
);

    localparam logic [N_LEN-1:0] LAST = N_LEN'(N - 1);

    logic [N_LEN-1:0] row_q;
    logic [N_LEN-1:0] col_q;

    // Advancing past the terminal element wraps to (0, 0) so an idle counter rests at origin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (clr_i) begin
            row_q <= '0;
            col_q <= '0;
        end else if (en_i) begin
            if (col_q == LAST) begin
                col_q <= '0;
                row_q <= (row_q == LAST) ? '0 : row_q + N_LEN'(1);
            end else begin
                col_q <= col_q + N_LEN'(1);
            end
        end
    end

    assign row_o = row_q;
    assign col_o = col_q;
    assign tc_o  = (row_q == LAST) && (col_q == LAST);

endmodule

// File: rtl/matrix_result_streamer.sv
// rtl/matrix_result_streamer.sv - drains the N x N result matrix as a valid/ready stream
module matrix_result_streamer
    import matmul_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int N_LEN  = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mul_done,
    output logic [N_LEN-1:0]  rd_i,
    output logic [N_LEN-1:0]  rd_j,
    input  logic [DATA_W-1:0] rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              frame_done,
    output logic [DATA_W-1:0] checksum,
    output logic              err
);

    state_t            state_q;
    logic [DATA_W-1:0] m_data_q;
    logic              m_valid_q;
    logic              m_last_q;
    logic              busy_q;
    logic              frame_done_q;
    logic [DATA_W-1:0] checksum_q;
    logic              err_q;
    logic              mul_done_q;

    logic accept;
    logic load;
    logic cnt_clr;
    logic tc;

    assign accept  = m_valid_q & m_ready;
    // The output register refills whenever it is empty or being drained this cycle.
    assign load    = (state_q == ST_STREAM) & (~m_valid_q | m_ready);
    assign cnt_clr = (state_q == ST_IDLE) & start;

    mat_index_counter #(
        .N     (N),
        .N_LEN (N_LEN)
    ) u_index (
        .clk   (clk),
        .rst_n (rst),
        .clr_i (cnt_clr),
        .en_i  (load),
        .row_o (rd_i),
        .col_o (rd_j),
        .tc_o  (tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            checksum_q   <= '0;
            err_q        <= 1'b0;
            mul_done_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            mul_done_q   <= mul_done;
            if (accept) begin
                checksum_q <= checksum_q ^ m_data_q;
            end
            if ((state_q == ST_STREAM || state_q == ST_FLUSH) && mul_done_q && !mul_done) begin
                err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_WAIT;
                        checksum_q <= '0;
                        err_q      <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (mul_done) begin
                        state_q <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (load) begin
                        m_data_q  <= rd_data;
                        m_valid_q <= 1'b1;
                        m_last_q  <= tc;
                        if (tc) begin
                            state_q <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (accept) begin
                        m_valid_q    <= 1'b0;
                        m_last_q     <= 1'b0;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign m_last     = m_last_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign checksum   = checksum_q;
    assign err        = err_q;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// tb/tb_matrix_result_streamer.sv - randomized self-checking bench for matrix_result_streamer
module tb_matrix_result_streamer;

    localparam int N      = 4;
    localparam int DATA_W = 32;
    localparam int N_LEN  = 2;
    localparam int NBEATS = N * N;

    logic              clk;
    logic              rst;
    logic              start;
    logic              mul_done;
    logic [N_LEN-1:0]  rd_i;
    logic [N_LEN-1:0]  rd_j;
    logic [DATA_W-1:0] rd_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              busy;
    logic              frame_done;
    logic [DATA_W-1:0] checksum;
    logic              err;

    int checks = 0;
    int passes = 0;

    logic [DATA_W-1:0] frame_seed;

    // Result matrix: R[i][j] = 16*i + j, optionally scrambled by a per-frame seed.
    assign rd_data = frame_seed ^ (32'(rd_i) * 32'd16 + 32'(rd_j));

    matrix_result_streamer #(
        .N      (N),
        .DATA_W (DATA_W),
        .N_LEN  (N_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mul_done   (mul_done),
        .rd_i       (rd_i),
        .rd_j       (rd_j),
        .rd_data    (rd_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .frame_done (frame_done),
        .checksum   (checksum),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] beats[$];
    logic              lasts[$];
    int                stall_bad;
    int                busy_bad;
    int                fd_early;
    bit                fd_ok;
    bit                timed_out;
    int                first_valid_cyc;
    int                final_cyc;

    function automatic logic [DATA_W-1:0] model_elem(input int k);
        return frame_seed ^ 32'(16 * (k / N) + (k % N));
    endfunction

    function automatic logic [DATA_W-1:0] model_xor();
        logic [DATA_W-1:0] x = '0;
        for (int k = 0; k < NBEATS; k++) x ^= model_elem(k);
        return x;
    endfunction

    function automatic int bad_beats();
        int b = 0;
        if (beats.size() != NBEATS) b++;
        for (int k = 0; k < beats.size(); k++) begin
            if (k >= NBEATS || beats[k] !== model_elem(k)) b++;
            if (lasts[k] !== (k == NBEATS - 1)) b++;
        end
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Collects one frame; mode 0 = ready always, 1 = random, 2 = pattern 1,0,0.
    task automatic drain(input int mode, input int start_beat, input int drop_beat);
        bit                prev_stall = 0;
        bit                final_seen = 0;
        bit                start_sent = 0;
        logic [DATA_W-1:0] prev_data  = '0;
        logic              prev_last  = 1'b0;
        beats.delete();
        lasts.delete();
        stall_bad = 0; busy_bad = 0; fd_early = 0;
        fd_ok = 0; timed_out = 1;
        first_valid_cyc = -1; final_cyc = -1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            start = 1'b0;
            if (final_seen) begin
                fd_ok = (frame_done === 1'b1) && (busy === 1'b0);
                timed_out = 0;
                break;
            end
            if (frame_done === 1'b1) fd_early++;
            if (busy !== 1'b1) busy_bad++;
            if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last))
                stall_bad++;
            if (m_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = (cyc % 3 == 0);
            endcase
            if (!start_sent && start_beat >= 0 && int'(beats.size()) == start_beat) begin
                start = 1'b1;
                start_sent = 1;
            end
            if (drop_beat >= 0 && int'(beats.size()) == drop_beat) mul_done = 1'b0;
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                beats.push_back(m_data);
                lasts.push_back(m_last);
                if (int'(beats.size()) == NBEATS) begin
                    final_seen = 1;
                    final_cyc = cyc;
                end
            end
            prev_stall = (m_valid === 1'b1) && (m_ready !== 1'b1);
            prev_data  = m_data;
            prev_last  = m_last;
            step();
        end
        start   = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; mul_done = 1'b0; m_ready = 1'b0; frame_seed = '0;
        repeat (3) step();
        checks++;
        if ({m_valid, m_last, busy, frame_done, err} !== 5'b0) begin
            $display("FAIL reset_flags: got %b required 00000", {m_valid, m_last, busy, frame_done, err});
        end else passes++;
        checks++;
        if (m_data !== '0 || checksum !== '0) begin
            $display("FAIL reset_data: m_data=%0h checksum=%0h required 0", m_data, checksum);
        end else passes++;
        checks++;
        if (rd_i !== '0 || rd_j !== '0) begin
            $display("FAIL reset_addr: rd_i=%0d rd_j=%0d required 0", rd_i, rd_j);
        end else passes++;
        rst = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        frame_seed = '0;
        mul_done   = 1'b0;
        do_start();
        repeat (5) step();
        mul_done = 1'b1;
        step();
        checks++;
        if (m_valid !== 1'b0) $display("FAIL b2b_latency_early: m_valid=%b required 0", m_valid);
        else passes++;
        step();
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'd0) begin
            $display("FAIL b2b_first_beat: m_valid=%b m_data=%0h required 1/0", m_valid, m_data);
        end else passes++;
        drain(0, -1, -1);
        checks++;
        if (timed_out || bad_beats() != 0) begin
            $display("FAIL b2b_beats: count=%0d bad=%0d timeout=%0b required 16/0/0", beats.size(), bad_beats(), timed_out);
        end else passes++;
        checks++;
        if (final_cyc - first_valid_cyc != NBEATS - 1) begin
            $display("FAIL b2b_throughput: span=%0d required %0d", final_cyc - first_valid_cyc, NBEATS - 1);
        end else passes++;
        checks++;
        if (checksum !== model_xor()) $display("FAIL b2b_checksum: got %0h required %0h", checksum, model_xor());
        else passes++;
        checks++;
        if (!fd_ok || fd_early != 0) $display("FAIL b2b_frame_done: ok=%0b early=%0d required 1/0", fd_ok, fd_early);
        else passes++;
        step();
        checks++;
        if (frame_done !== 1'b0) $display("FAIL b2b_frame_done_pulse: got %b required 0", frame_done);
        else passes++;
    endtask

    task automatic test_backpressure();
        for (int mode = 1; mode <= 2; mode++) begin
            frame_seed = $urandom;
            mul_done   = 1'b1;
            do_start();
            drain(mode, -1, -1);
            checks++;
            if (timed_out || bad_beats() != 0) begin
                $display("FAIL bp_beats mode %0d: count=%0d bad=%0d required 16/0", mode, beats.size(), bad_beats());
            end else passes++;
            checks++;
            if (stall_bad != 0) $display("FAIL bp_stable mode %0d: violations=%0d required 0", mode, stall_bad);
            else passes++;
            checks++;
            if (checksum !== model_xor() || !fd_ok) begin
                $display("FAIL bp_checksum mode %0d: got %0h required %0h fd=%0b", mode, checksum, model_xor(), fd_ok);
            end else passes++;
        end
    endtask

    task automatic test_start_ignored();
        frame_seed = $urandom;
        mul_done   = 1'b1;
        do_start();
        drain(1, 7, -1);
        checks++;
        if (timed_out || bad_beats() != 0) begin
            $display("FAIL ign_beats: count=%0d bad=%0d required 16/0", beats.size(), bad_beats());
        end else passes++;
        checks++;
        if (busy_bad != 0 || !fd_ok) $display("FAIL ign_busy: busy_low=%0d fd=%0b required 0/1", busy_bad, fd_ok);
        else passes++;
        checks++;
        if (checksum !== model_xor()) $display("FAIL ign_checksum: got %0h required %0h", checksum, model_xor());
        else passes++;
        repeat (3) step();
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0) $display("FAIL ign_rearm: busy=%b m_valid=%b required 0/0", busy, m_valid);
        else passes++;
    endtask

    task automatic test_err();
        frame_seed = $urandom;
        mul_done   = 1'b1;
        do_start();
        checks++;
        if (err !== 1'b0) $display("FAIL err_initial: got %b required 0", err);
        else passes++;
        drain(0, -1, 9);
        checks++;
        if (timed_out || bad_beats() != 0) begin
            $display("FAIL err_beats: count=%0d bad=%0d required 16/0", beats.size(), bad_beats());
        end else passes++;
        repeat (4) step();
        checks++;
        if (err !== 1'b1) $display("FAIL err_sticky: got %b required 1", err);
        else passes++;
        mul_done = 1'b1;
        step();
        do_start();
        checks++;
        if (err !== 1'b0) $display("FAIL err_clear: got %b required 0", err);
        else passes++;
        drain(0, -1, -1);
        checks++;
        if (err !== 1'b0 || checksum !== model_xor()) begin
            $display("FAIL err_next_frame: err=%b checksum=%0h required 0/%0h", err, checksum, model_xor());
        end else passes++;
    endtask

    task automatic test_reset_mid();
        int acc = 0;
        int bad = 0;
        frame_seed = $urandom;
        mul_done   = 1'b1;
        m_ready    = 1'b1;
        do_start();
        for (int cyc = 0; cyc < 100 && acc < 5; cyc++) begin
            if (m_valid === 1'b1) acc++;
            step();
        end
        rst = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || checksum !== '0) begin
            $display("FAIL rst_mid: m_valid=%b busy=%b checksum=%0h accepted=%0d required 0/0/0", m_valid, busy, checksum, acc);
        end else passes++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (m_valid !== 1'b0 || busy !== 1'b0) bad++;
            step();
        end
        m_ready = 1'b0;
        checks++;
        if (bad != 0) $display("FAIL rst_no_beats: active cycles=%0d required 0", bad);
        else passes++;
    endtask

    task automatic test_wait_hold();
        int bad = 0;
        frame_seed = $urandom;
        mul_done   = 1'b0;
        do_start();
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (m_valid !== 1'b0 || busy !== 1'b1 || rd_i !== '0 || rd_j !== '0) bad++;
            step();
        end
        checks++;
        if (bad != 0) $display("FAIL wait_hold: bad cycles=%0d required 0", bad);
        else passes++;
        mul_done = 1'b1;
        step();
        step();
        checks++;
        if (m_valid !== 1'b1 || m_data !== model_elem(0)) begin
            $display("FAIL wait_first: m_valid=%b m_data=%0h required 1/%0h", m_valid, m_data, model_elem(0));
        end else passes++;
        drain(1, -1, -1);
        checks++;
        if (timed_out || bad_beats() != 0 || checksum !== model_xor()) begin
            $display("FAIL wait_frame: count=%0d bad=%0d checksum=%0h required 16/0/%0h", beats.size(), bad_beats(), checksum, model_xor());
        end else passes++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_start_ignored();
        test_err();
        test_reset_mid();
        test_wait_hold();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
